present_sbox_layer_seq: RTL and testbench

//  Sequences one PRESENT S-box layer over a 64-bit, 3-share masked state through a single

---
 rtl/present_mask_pkg.sv | 32 +++
 rtl/present_seq_prng.sv | 50 +++++
 rtl/present_sbox_layer_seq.sv | 185 ++++++++++++++++++
 tb/tb_present_sbox_layer_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_mask_pkg.sv
// ============================================================================
//  Module      : present_mask_pkg
//  Description : Shared constants, FSM state type and PRESENT S-box table for
//                the masked PRESENT datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package present_mask_pkg;

  localparam int NIBBLES  = 16;
  localparam int SHARES   = 3;
  localparam int SBOX_R_W = 45;
  localparam int RS_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Nibble i of this constant is S(i); used as the unmasked reference table.
  localparam logic [63:0] PRESENT_SBOX = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    return PRESENT_SBOX[{x, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/present_seq_prng.sv
// ============================================================================
//  Module      : present_seq_prng
//  Description : 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1), advanced STEPS
//                times per clock, low OUT_W bits exported as S-box randomness.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_seq_prng
  import present_mask_pkg::*;
#(
  parameter int STEPS = SBOX_R_W,
  parameter int OUT_W = SBOX_R_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_seed_ld,
  input  logic [63:0]      i_seed,
  output logic [OUT_W-1:0] o_r
);

  localparam logic [63:0] C_RESET_STATE = 64'hACE1_0000_0000_0001;

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < STEPS; i++) begin
      v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    end
    return v;
  endfunction

  logic [63:0] r_state;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_RESET_STATE;
    end else if (i_seed_ld) begin
      r_state <= (i_seed == 64'd0) ? 64'd1 : i_seed;
    end else begin
      r_state <= lfsr_adv(r_state);
    end
  end

  assign o_r = r_state[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/present_sbox_layer_seq.sv
// ============================================================================
//  Module      : present_sbox_layer_seq
//  Description : Streams a 3-share 64-bit state one nibble per cycle through a
//                shared pipelined masked S-box and reassembles the result.
//                Build option PRESENT_SEQ_PRNG_EN selects internal randomness.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_sbox_layer_seq
  import present_mask_pkg::*;
#(
  parameter int SBOX_LAT = 3,
  parameter int R_W      = SBOX_R_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [63:0]     i_st1,
  input  logic [63:0]     i_st2,
  input  logic [63:0]     i_st3,
  output logic            o_busy,
  output logic            o_done,
  output logic [63:0]     o_res1,
  output logic [63:0]     o_res2,
  output logic [63:0]     o_res3,
  output logic [3:0]      o_sb_in1,
  output logic [3:0]      o_sb_in2,
  output logic [3:0]      o_sb_in3,
  output logic [R_W-1:0]  o_sb_r,
  output logic [RS_W-1:0] o_sb_rs_in,
  input  logic [RS_W-1:0] i_sb_rs_out,
  input  logic [3:0]      i_sb_out1,
  input  logic [3:0]      i_sb_out2,
  input  logic [3:0]      i_sb_out3,
`ifdef PRESENT_SEQ_PRNG_EN
  input  logic            i_seed_ld,
  input  logic [63:0]     i_seed
`else
  input  logic [R_W-1:0]  i_ext_r
`endif
);

  localparam logic [3:0] C_LAST_NIB = 4'(NIBBLES - 1);

  seq_state_t          r_state;
  logic [63:0]         r_sh1, r_sh2, r_sh3;
  logic [63:0]         r_acc1, r_acc2, r_acc3;
  logic [63:0]         w_acc1, w_acc2, w_acc3;
  logic [63:0]         r_res1, r_res2, r_res3;
  logic [3:0]          r_rd_idx;
  logic [3:0]          r_wr_idx;
  logic [SBOX_LAT-1:0] r_vpipe;
  logic [RS_W-1:0]     r_rs_in;
  logic                r_busy;
  logic                r_done;
  logic                w_feed;
  logic                w_cap;
  logic                w_last;

  assign w_feed = (r_state == FEED);
  assign w_cap  = r_vpipe[SBOX_LAT-1];
  assign w_last = w_cap && (r_wr_idx == C_LAST_NIB);

  // Shares stay separate end to end; each is sliced and merged on its own.
  assign o_sb_in1 = w_feed ? r_sh1[{r_rd_idx, 2'b00} +: 4] : 4'h0;
  assign o_sb_in2 = w_feed ? r_sh2[{r_rd_idx, 2'b00} +: 4] : 4'h0;
  assign o_sb_in3 = w_feed ? r_sh3[{r_rd_idx, 2'b00} +: 4] : 4'h0;

  always_comb begin
    w_acc1 = r_acc1;
    w_acc2 = r_acc2;
    w_acc3 = r_acc3;
    if (w_cap) begin
      w_acc1[{r_wr_idx, 2'b00} +: 4] = i_sb_out1;
      w_acc2[{r_wr_idx, 2'b00} +: 4] = i_sb_out2;
      w_acc3[{r_wr_idx, 2'b00} +: 4] = i_sb_out3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sh1    <= 64'd0;
      r_sh2    <= 64'd0;
      r_sh3    <= 64'd0;
      r_acc1   <= 64'd0;
      r_acc2   <= 64'd0;
      r_acc3   <= 64'd0;
      r_res1   <= 64'd0;
      r_res2   <= 64'd0;
      r_res3   <= 64'd0;
      r_rd_idx <= 4'd0;
      r_wr_idx <= 4'd0;
      r_vpipe  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_acc1     <= w_acc1;
      r_acc2     <= w_acc2;
      r_acc3     <= w_acc3;
      r_vpipe[0] <= w_feed;
      for (int i = 1; i < SBOX_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
      if (w_cap) begin
        r_wr_idx <= r_wr_idx + 4'd1;
      end

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_sh1    <= i_st1;
            r_sh2    <= i_st2;
            r_sh3    <= i_st3;
            r_rd_idx <= 4'd0;
            r_busy   <= 1'b1;
            r_state  <= FEED;
          end
        end
        FEED: begin
          r_rd_idx <= r_rd_idx + 4'd1;
          if (r_rd_idx == C_LAST_NIB) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // The final nibble lands in the same edge that publishes the result.
          if (w_last) begin
            r_res1  <= w_acc1;
            r_res2  <= w_acc2;
            r_res3  <= w_acc3;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_in <= '0;
    end else begin
      r_rs_in <= i_sb_rs_out;
    end
  end

`ifdef PRESENT_SEQ_PRNG_EN
  logic [R_W-1:0] w_prng_r;

  present_seq_prng #(
    .STEPS (R_W),
    .OUT_W (R_W)
  ) u_prng (
    .clk       (clk),
    .rst       (rst),
    .i_seed_ld (i_seed_ld),
    .i_seed    (i_seed),
    .o_r       (w_prng_r)
  );

  assign o_sb_r = w_prng_r;
`else
  assign o_sb_r = i_ext_r;
`endif

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_res1     = r_res1;
  assign o_res2     = r_res2;
  assign o_res3     = r_res3;
  assign o_sb_rs_in = r_rs_in;

endmodule

`default_nettype wire

// File: tb/tb_present_sbox_layer_seq.sv
// ============================================================================
//  Module      : tb_present_sbox_layer_seq
//  Description : Scoreboard bench for present_sbox_layer_seq with a behavioural
//                3-share pipelined S-box that re-masks from o_sb_r.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_present_sbox_layer_seq;
  import present_mask_pkg::*;

  localparam int SBOX_LAT = 3;
  localparam int R_W      = SBOX_R_W;
  localparam int LATENCY  = 17 + SBOX_LAT;

  localparam logic [63:0] C_PT    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] C_CT    = 64'hC56B_90AD_3EF8_4712;
  localparam logic [63:0] C_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] C_TWOS  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] C_ELEV  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] C_FIVES = 64'h5555_5555_5555_5555;
  localparam logic [63:0] C_CS    = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] C_M2    = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] C_M3    = 64'h1357_9BDF_2468_ACE0;
  localparam logic [R_W-1:0] C_EXT = 45'h1_2345_6789_A;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [63:0]     i_st1, i_st2, i_st3;
  logic            o_busy, o_done;
  logic [63:0]     o_res1, o_res2, o_res3;
  logic [3:0]      o_sb_in1, o_sb_in2, o_sb_in3;
  logic [R_W-1:0]  o_sb_r;
  logic [RS_W-1:0] o_sb_rs_in;
  logic [RS_W-1:0] i_sb_rs_out;
  logic [3:0]      i_sb_out1, i_sb_out2, i_sb_out3;
`ifdef PRESENT_SEQ_PRNG_EN
  logic            i_seed_ld;
  logic [63:0]     i_seed;
`else
  logic [R_W-1:0]  i_ext_r;
  bit              fix_ext = 1'b0;
`endif

  always #5 clk = ~clk;

  present_sbox_layer_seq #(
    .SBOX_LAT (SBOX_LAT),
    .R_W      (R_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_st1       (i_st1),
    .i_st2       (i_st2),
    .i_st3       (i_st3),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_res1      (o_res1),
    .o_res2      (o_res2),
    .o_res3      (o_res3),
    .o_sb_in1    (o_sb_in1),
    .o_sb_in2    (o_sb_in2),
    .o_sb_in3    (o_sb_in3),
    .o_sb_r      (o_sb_r),
    .o_sb_rs_in  (o_sb_rs_in),
    .i_sb_rs_out (i_sb_rs_out),
    .i_sb_out1   (i_sb_out1),
    .i_sb_out2   (i_sb_out2),
    .i_sb_out3   (i_sb_out3),
`ifdef PRESENT_SEQ_PRNG_EN
    .i_seed_ld   (i_seed_ld),
    .i_seed      (i_seed)
`else
    .i_ext_r     (i_ext_r)
`endif
  );

  // Masked S-box stand-in: output shares are {S(x)^m1^m2, m1, m2}.
  logic [11:0] r_sb_pipe [SBOX_LAT];
  always @(posedge clk) begin
    r_sb_pipe[0] <= {present_sbox(o_sb_in1 ^ o_sb_in2 ^ o_sb_in3) ^ o_sb_r[3:0] ^ o_sb_r[7:4],
                     o_sb_r[3:0], o_sb_r[7:4]};
    for (int i = 1; i < SBOX_LAT; i++) r_sb_pipe[i] <= r_sb_pipe[i-1];
  end
  assign {i_sb_out1, i_sb_out2, i_sb_out3} = r_sb_pipe[SBOX_LAT-1];

  logic [RS_W-1:0] r_rs_src = 8'h5A;
  logic [RS_W-1:0] r_rs_exp = 8'h00;
  bit              r_rs_ok  = 1'b0;
  always @(posedge clk) begin
    r_rs_src <= r_rs_src * 8'd5 + 8'd3;
    r_rs_exp <= r_rs_src;
    r_rs_ok  <= !rst;
  end
  assign i_sb_rs_out = r_rs_src;

`ifndef PRESENT_SEQ_PRNG_EN
  always @(negedge clk) i_ext_r = fix_ext ? C_EXT : R_W'({$urandom, $urandom});
`endif

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] value;
    int unsigned due;
    bit          chk_shares;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
    n_cmp++;
    if (act === bad) begin
      n_bad++;
      $display("FAIL %s: got %h, required anything but %h", name, act, bad);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (r_rs_ok) chk("rs_recycle", 64'(o_sb_rs_in), 64'(r_rs_exp));
      if (o_done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("busy_at_done", 64'(o_busy), 64'd0);
          chk("res_xor", o_res1 ^ o_res2 ^ o_res3, e.value);
          if (e.chk_shares) begin
            chk_ne("res1_masked", o_res1, e.value);
            chk_ne("res2_masked", o_res2, e.value);
            chk_ne("res3_masked", o_res3, e.value);
          end
        end
      end else if (q.size() != 0 && cyc >= q[0].due) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_missing: no done by cycle %0d, required done at %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic launch(input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] s3,
                        input logic [63:0] expv, input bit chk_sh, output int unsigned t0);
    exp_t e;
    @(negedge clk);
    i_start = 1'b1;
    i_st1   = s1;
    i_st2   = s2;
    i_st3   = s3;
    t0      = cyc;
    e.value = expv;
    e.due   = t0 + LATENCY;
    e.chk_shares = chk_sh;
    q.push_back(e);
    @(negedge clk);
    // Inputs are scrambled once accepted; the result must come from the latched copy.
    i_start = 1'b0;
    i_st1   = {$urandom, $urandom};
    i_st2   = {$urandom, $urandom};
    i_st3   = {$urandom, $urandom};
    #1 chk("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start_at(input int unsigned target);
    wait_cyc(target);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation time %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t0;
    int unsigned t1;
    logic [R_W-1:0] prev_r;
    rst     = 1'b1;
    i_start = 1'b0;
    i_st1   = 64'd0;
    i_st2   = 64'd0;
    i_st3   = 64'd0;
`ifdef PRESENT_SEQ_PRNG_EN
    i_seed_ld = 1'b0;
    i_seed    = 64'd0;
`endif
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_res1", o_res1, 64'd0);
    chk("reset_res2", o_res2, 64'd0);
    chk("reset_res3", o_res3, 64'd0);
    chk("reset_sb_in", 64'({o_sb_in1, o_sb_in2, o_sb_in3}), 64'd0);
    chk("reset_rs_in", 64'(o_sb_rs_in), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    launch(C_PT, 64'd0, 64'd0, C_CT, 1'b0, t0);
    wait_drain();

    launch(C_PT ^ C_M2 ^ C_M3, C_M2, C_M3, C_CT, 1'b1, t0);
    wait_drain();

    // Starts during FEED, DRAIN and DONE are dropped; the IDLE cycle after done accepts.
    launch(C_PT, 64'd0, 64'd0, C_CT, 1'b0, t0);
    pulse_start_at(t0 + 5);
    pulse_start_at(t0 + 16);
    wait_cyc(t0 + LATENCY);
    i_start = 1'b1;
    i_st1   = C_ELEV;
    i_st2   = 64'd0;
    i_st3   = 64'd0;
    launch(C_ELEV, 64'd0, 64'd0, C_FIVES, 1'b0, t1);
    wait_drain();

    launch(C_PT, 64'd0, 64'd0, C_CT, 1'b0, t0);
    wait_cyc(t0 + 10);
    q.delete();
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_done", 64'(o_done), 64'd0);
    chk("abort_res1", o_res1, 64'd0);
    chk("abort_res2", o_res2, 64'd0);
    chk("abort_res3", o_res3, 64'd0);
    chk("abort_sb_in", 64'({o_sb_in1, o_sb_in2, o_sb_in3}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(C_ONES, 64'd0, 64'd0, C_TWOS, 1'b0, t0);
    wait_drain();

    launch(64'd0, 64'd0, 64'd0, C_CS, 1'b0, t0);
    wait_drain();
    launch(C_ELEV, 64'd0, 64'd0, C_FIVES, 1'b0, t0);
    wait_drain();

`ifdef PRESENT_SEQ_PRNG_EN
    @(negedge clk);
    i_seed_ld = 1'b1;
    i_seed    = 64'd0;
    @(negedge clk);
    i_seed_ld = 1'b0;
    #1;
    chk_ne("prng_nonzero", 64'(o_sb_r), 64'd0);
    prev_r = o_sb_r;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk_ne("prng_nonzero", 64'(o_sb_r), 64'd0);
      chk_ne("prng_changes", 64'(o_sb_r), 64'(prev_r));
      prev_r = o_sb_r;
    end
`else
    fix_ext = 1'b1;
    @(negedge clk);
    #1;
    chk("ext_r_pass", 64'(o_sb_r), 64'(C_EXT));
    prev_r  = o_sb_r;
    fix_ext = 1'b0;
    @(negedge clk);
    #1;
    chk("ext_r_follow", 64'(o_sb_r), 64'(i_ext_r));
    chk_ne("ext_r_refresh", 64'(o_sb_r), 64'(prev_r));
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
